// File: rtl/mem_unit.sv
// mem_unit: word-addressed 16-bit synchronous memory that answers the
// processor's memory interface (addr/we/toMem -> fromMem, one-cycle read).
// After reset it zeroes every word, then serves the processor. A streaming
// load port writes program images into consecutive words while the processor
// port is held off (busy).
module mem_unit #(
  parameter int DEPTH = 256,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [15:0]   toMem,
  output logic [15:0]   fromMem,
  output logic          busy,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic          ld_valid,
  input  logic [15:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_err
);

  // Index width for the storage array; addresses are range-checked against
  // DEPTH before the low bits are used as an index.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Comparison constants at pointer width (AW+1 bits) so the load pointer
  // can step one past the top of a full 2**AW space without wrapping.
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_X  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_X   = (AW+1)'(1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    SERVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [AW:0]   ptr_reg;
  logic [AW:0]   ptr_next;
  logic          err_reg;
  logic          err_next;
  logic [15:0]   rd_reg;

  // Storage: no reset; CLEAR walks every word to zero instead.
  logic [15:0]   mem [DEPTH];

  // Single write port shared by CLEAR, the processor and the load stream.
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;

  logic          addr_ok;
  logic          ptr_ok;

  assign addr_ok = ({1'b0, addr} < DEPTH_X);
  assign ptr_ok  = (ptr_reg < DEPTH_X);

  // State, load/clear pointer and overflow flag; reset restarts the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic and selection of who owns the write port this cycle.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    err_next   = err_reg;
    mem_we     = 1'b0;
    mem_waddr  = addr[IW-1:0];
    mem_wdata  = toMem;

    case (state_reg)
      CLEAR: begin
        // One word per cycle; processor and load inputs are ignored.
        mem_we    = 1'b1;
        mem_waddr = ptr_reg[IW-1:0];
        mem_wdata = 16'h0000;
        ptr_next  = ptr_reg + ONE_X;
        if (ptr_reg == LAST_X) begin
          state_next = SERVE;
        end
      end

      SERVE: begin
        // Out-of-range processor writes are dropped.
        mem_we    = we & addr_ok;
        mem_waddr = addr[IW-1:0];
        mem_wdata = toMem;
        if (ld_start) begin
          ptr_next   = {1'b0, ld_base};
          err_next   = 1'b0;
          state_next = LOAD;
        end
      end

      LOAD: begin
        if (ld_valid) begin
          if (ptr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_reg[IW-1:0];
            mem_wdata = ld_data;
            ptr_next  = ptr_reg + ONE_X;
            if (ld_last) begin
              state_next = SERVE;
            end
          end else begin
            // Burst ran past the top of memory: drop the word, flag it and
            // give the port back to the processor.
            err_next   = 1'b1;
            state_next = SERVE;
          end
        end
      end

      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read: sees the pre-edge contents, so a same-edge write
  // returns the old word. Held in LOAD, forced to zero while clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_reg <= 16'h0000;
    end else begin
      case (state_reg)
        CLEAR:   rd_reg <= 16'h0000;
        SERVE:   rd_reg <= addr_ok ? mem[addr[IW-1:0]] : 16'h0000;
        default: rd_reg <= rd_reg;
      endcase
    end
  end

  assign fromMem  = rd_reg;
  assign busy     = (state_reg != SERVE);
  assign ld_ready = (state_reg == LOAD);
  assign ld_err   = err_reg;

endmodule
